// File: rtl/ring_johnson_ctr.sv
// Ring/Johnson shift-register sequence counter with direction, parallel load, step index and wrap pulse.
// Optional self-correction of illegal patterns is enabled by defining RING_CTR_SELFCORR_EN.
module ring_johnson_ctr #(
  parameter int unsigned WIDTH   = 4,
  parameter bit          JOHNSON = 1'b0,
  localparam int unsigned PW     = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             err
);

  localparam int unsigned    P        = JOHNSON ? 2 * WIDTH : WIDTH;
  localparam logic [WIDTH-1:0] RING_RST = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] RST_VAL  = JOHNSON ? {WIDTH{1'b0}} : RING_RST;
  localparam logic [PW-1:0]    POS_MAX  = PW'(P - 1);

  logic [WIDTH-1:0] out_q, out_d, shift_r_c, shift_l_c;
  logic [PW-1:0]    pos_q, pos_d, pos_step_c;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             fb_r_c, fb_l_c;
  logic             illegal_c;

  // Feedback bit: straight for ring, inverted (twisted) for Johnson
  assign fb_r_c    = JOHNSON ? ~out_q[0]       : out_q[0];
  assign fb_l_c    = JOHNSON ? ~out_q[WIDTH-1] : out_q[WIDTH-1];
  assign shift_r_c = {fb_r_c, out_q[WIDTH-1:1]};
  assign shift_l_c = {out_q[WIDTH-2:0], fb_l_c};

  // Step index is modulo P, which is not a power of two in general
  always_comb begin
    pos_step_c = pos_q;
    if (!dir) begin
      pos_step_c = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
    end else begin
      pos_step_c = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
    end
  end

`ifdef RING_CTR_SELFCORR_EN
  // Ring: exactly one hot bit. Johnson: at most one non-circular adjacent transition.
  always_comb begin
    illegal_c = 1'b0;
    if (JOHNSON) begin
      illegal_c = ($countones(out_q[WIDTH-1:1] ^ out_q[WIDTH-2:0]) > 1);
    end else begin
      illegal_c = !$onehot(out_q);
    end
  end
`else
  assign illegal_c = 1'b0;
`endif

  // Next state: load > enabled step (or recovery) > hold
  always_comb begin
    out_d  = out_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (load) begin
      out_d = load_val;
      pos_d = '0;
    end else if (en) begin
      if (illegal_c) begin
        out_d = RST_VAL;
        pos_d = '0;
        err_d = 1'b1;
      end else begin
        out_d  = dir ? shift_l_c : shift_r_c;
        pos_d  = pos_step_c;
        wrap_d = (pos_step_c == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_q  <= RST_VAL;
      pos_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign out  = out_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ring_johnson_ctr.sv
// Directed table-driven bench for ring_johnson_ctr (WIDTH=4): a ring and a Johnson instance share stimulus.
// Illegal-pattern expectations follow RING_CTR_SELFCORR_EN.
module tb_ring_johnson_ctr;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 3;

  logic          clk = 1'b0;
  logic          rstn, en, dir, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  r_out, j_out;
  logic [PW-1:0] r_pos, j_pos;
  logic          r_wrap, j_wrap, r_err, j_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ring_johnson_ctr #(.WIDTH(W), .JOHNSON(1'b0)) u_ring (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .out(r_out), .pos(r_pos), .wrap(r_wrap), .err(r_err)
  );

  ring_johnson_ctr #(.WIDTH(W), .JOHNSON(1'b1)) u_john (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .out(j_out), .pos(j_pos), .wrap(j_wrap), .err(j_err)
  );

  typedef struct {
    logic          rstn, en, dir, load;
    logic [W-1:0]  lv;
    logic [W-1:0]  eo;
    logic [PW-1:0] ep;
    logic          ew;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic e, logic d, logic l, logic [W-1:0] lv,
                              logic [W-1:0] eo, logic [PW-1:0] ep, logic ew);
    vec_t v;
    v.rstn = r; v.en = e; v.dir = d; v.load = l; v.lv = lv;
    v.eo = eo; v.ep = ep; v.ew = ew;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle before sampling
  task automatic apply(logic r, logic e, logic d, logic l, logic [W-1:0] lv);
    rstn = r; en = e; dir = d; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0]  jexp [8];
    logic [W-1:0]  exp6_r, exp6_j, exp7_r;
    logic          exp6_err;

    rstn = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;

    // rstn en dir load load_val | out pos wrap
    add(0, 0, 0, 0, 4'b0000, 4'b1000, 3'd0, 0);
    add(1, 1, 0, 0, 4'b0000, 4'b0100, 3'd1, 0);
    add(1, 1, 0, 0, 4'b0000, 4'b0010, 3'd2, 0);
    add(1, 1, 0, 0, 4'b0000, 4'b0001, 3'd3, 0);
    add(1, 1, 0, 0, 4'b0000, 4'b1000, 3'd0, 1);
    add(1, 0, 0, 0, 4'b0000, 4'b1000, 3'd0, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b1000, 3'd0, 0);
    add(1, 1, 1, 0, 4'b0000, 4'b0001, 3'd3, 0);
    add(1, 1, 1, 0, 4'b0000, 4'b0010, 3'd2, 0);
    add(1, 1, 1, 0, 4'b0000, 4'b0100, 3'd1, 0);
    add(1, 1, 1, 0, 4'b0000, 4'b1000, 3'd0, 1);
    add(1, 1, 0, 0, 4'b0000, 4'b0100, 3'd1, 0);
    add(1, 1, 1, 0, 4'b0000, 4'b1000, 3'd0, 1);
    add(1, 1, 0, 1, 4'b0010, 4'b0010, 3'd0, 0);
    add(1, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 0);
    add(1, 1, 0, 0, 4'b0000, 4'b1000, 3'd2, 0);
    add(0, 1, 0, 1, 4'b0001, 4'b1000, 3'd0, 0);
    add(1, 0, 0, 0, 4'b0000, 4'b1000, 3'd0, 0);
    add(1, 0, 1, 0, 4'b0000, 4'b1000, 3'd0, 0);
    add(1, 0, 0, 0, 4'b0000, 4'b1000, 3'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rstn, vecs[i].en, vecs[i].dir, vecs[i].load, vecs[i].lv);
      chk($sformatf("v%0d.out", i),  32'(r_out),  32'(vecs[i].eo));
      chk($sformatf("v%0d.pos", i),  32'(r_pos),  32'(vecs[i].ep));
      chk($sformatf("v%0d.wrap", i), 32'(r_wrap), 32'(vecs[i].ew));
      chk($sformatf("v%0d.err", i),  32'(r_err),  32'(1'b0));
    end

    // Johnson full period forward from reset
    jexp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    apply(0, 0, 0, 0, '0);
    chk("j_rst.out", 32'(j_out), 32'(4'b0000));
    chk("j_rst.pos", 32'(j_pos), 32'(0));
    for (int i = 0; i < 8; i++) begin
      apply(1, 1, 0, 0, '0);
      chk($sformatf("j%0d.out", i),  32'(j_out),  32'(jexp[i]));
      chk($sformatf("j%0d.pos", i),  32'(j_pos),  32'((i + 1) % 8));
      chk($sformatf("j%0d.wrap", i), 32'(j_wrap), 32'(i == 7));
    end
    apply(1, 1, 1, 0, '0);
    chk("j_left.out", 32'(j_out), 32'(4'b0001));
    chk("j_left.pos", 32'(j_pos), 32'(7));
    chk("j_left.wrap", 32'(j_wrap), 32'(0));

    // Illegal pattern load then step
`ifdef RING_CTR_SELFCORR_EN
    exp6_r = 4'b1000; exp6_j = 4'b0000; exp6_err = 1'b1; exp7_r = 4'b0100;
`else
    exp6_r = 4'b0011; exp6_j = 4'b1011; exp6_err = 1'b0; exp7_r = 4'b1001;
`endif
    apply(0, 0, 0, 0, '0);
    apply(1, 0, 0, 1, 4'b0110);
    chk("ill_load.out", 32'(r_out), 32'(4'b0110));
    chk("ill_load.err", 32'(r_err), 32'(0));
    apply(1, 1, 0, 0, '0);
    chk("ill_step.r_out", 32'(r_out), 32'(exp6_r));
    chk("ill_step.r_pos", 32'(r_pos), 32'(exp6_r == 4'b1000 ? 0 : 1));
    chk("ill_step.r_err", 32'(r_err), 32'(exp6_err));
    chk("ill_step.j_out", 32'(j_out), 32'(exp6_j));
    chk("ill_step.j_err", 32'(j_err), 32'(exp6_err));
    apply(1, 1, 0, 0, '0);
    chk("ill_next.r_out", 32'(r_out), 32'(exp7_r));
    chk("ill_sticky.r_err", 32'(r_err), 32'(exp6_err));
    apply(1, 0, 0, 1, 4'b0100);
    chk("ill_load_keep.r_err", 32'(r_err), 32'(exp6_err));
    apply(0, 0, 0, 0, '0);
    chk("ill_rst.r_err", 32'(r_err), 32'(0));
    chk("ill_rst.j_err", 32'(j_err), 32'(0));
    chk("ill_rst.r_out", 32'(r_out), 32'(4'b1000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
